// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the instruction-side front end: the NOP encoding
// presented to decode when nothing is valid, the legal ROM fetch window
// (shared by the ROM and the fetch unit so both agree), and the fetch queue
// entry format.
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
    localparam int unsigned ROM_BYTES = 4096;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous DEPTH-entry FIFO of fetch_entry_t with flush.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   flush       empties the queue; overrides push and pop
//   push, wdata write wdata at the tail (ignored when full unless popping)
//   pop         retire the head entry (ignored when empty)
//   rdata       head entry (contents undefined when empty)
//   count       number of valid entries, 0..DEPTH
//   full, empty occupancy flags
//
// Only pointers and count are reset; storage is qualified by count.
// ---------------------------------------------------------------------------
module fetch_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // A full queue may still accept a push when the head leaves in the
    // same cycle; an empty queue never bypasses, so pop is simply ignored.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of a combinational instruction ROM.
// Owns the PC, drives the word-aligned ROM address, captures ROM data into
// a small fetch queue and presents the head entry to decode over
// valid/ready. A redirect from execute flushes the queue and reloads the PC.
// A fetch from a misaligned or out-of-window PC is queued with fault set and
// stops fetching until the next redirect.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_addr        ROM byte address {pc[31:2],2'b00}
//   imem_rdata       ROM read data for imem_addr (combinational)
//   redirect_valid   execute requests a PC change this cycle
//   redirect_pc      redirect target
//   id_ready         decode accepts the head entry
//   id_valid         head entry valid
//   id_instr         head instruction, NOP when empty
//   id_pc            head PC, 0 when empty
//   id_pc_plus4      head PC + 4, 0 when empty
//   id_fault         head entry fetched from an illegal PC
// ---------------------------------------------------------------------------
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] ROM_BASE  = rv32_pkg::ROM_BASE,
    parameter int unsigned ROM_BYTES = rv32_pkg::ROM_BYTES,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_fault
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // 33 bits so a window ending exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] ROM_LIMIT = {1'b0, ROM_BASE} + 33'(ROM_BYTES);

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             halted;
    logic             fault_now;
    logic             enq;
    logic             deq;
    fetch_entry_t     q_wdata;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = {pc[31:2], 2'b00};

    assign fault_now = (pc[1:0] != 2'b00)
                    || (pc < ROM_BASE)
                    || ({1'b0, pc} >= ROM_LIMIT);

    assign deq = id_valid && id_ready;
    assign enq = !redirect_valid && !halted && (!q_full || deq);

    assign q_wdata = '{instr:    imem_rdata,
                       pc:       pc,
                       pc_plus4: pc_plus4,
                       fault:    fault_now};

    // PC / halt: redirect wins; a faulting fetch freezes the PC so the
    // offending address stays visible until execute steers elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
        end else if (enq) begin
            if (fault_now) halted <= 1'b1;
            else           pc     <= pc_plus4;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (enq),
        .wdata (q_wdata),
        .pop   (deq),
        .rdata (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign id_valid    = (q_count != '0);
    assign id_instr    = q_empty ? NOP_INSTR : q_head.instr;
    assign id_pc       = q_empty ? 32'd0     : q_head.pc;
    assign id_pc_plus4 = q_empty ? 32'd0     : q_head.pc_plus4;
    assign id_fault    = q_empty ? 1'b0      : q_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a combinational ROM model whose word at
// each address is addr ^ 32'h1357_9BDF.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_fault;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = rom_word(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_fault       (id_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks a valid head entry against the ROM model at address a.
    task automatic check_entry(input string tag, input logic [31:0] a, input logic flt);
        check({tag, ".valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, ".pc"},    id_pc, a);
        check({tag, ".pc4"},   id_pc_plus4, a + 32'd4);
        check({tag, ".instr"}, id_instr, rom_word({a[31:2], 2'b00}));
        check({tag, ".fault"}, {31'd0, id_fault}, {31'd0, flt});
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, ".instr"}, id_instr, NOP);
        check({tag, ".pc"},    id_pc, 32'd0);
        check({tag, ".pc4"},   id_pc_plus4, 32'd0);
        check({tag, ".fault"}, {31'd0, id_fault}, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_empty("rst");
        check("rst.addr", imem_addr, BASE);
        rst_n = 1'b1;

        // First fetch visible one cycle after the first edge, then streaming
        tick();
        check_entry("e0", BASE, 1'b0);
        check("e0.addr", imem_addr, BASE + 32'd4);
        tick();
        check_entry("e1", BASE + 32'd4, 1'b0);

        // Stall to fill the queue, then asynchronous reset mid-cycle
        id_ready = 1'b0;
        tick();
        check("full.pc", id_pc, BASE + 32'd4);
        check("full.addr", imem_addr, BASE + 32'd12);
        #2 rst_n = 1'b0;
        #1;
        check_empty("arst");
        check("arst.addr", imem_addr, BASE);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall 5 cycles from reset: exactly two entries, PC parks at +8
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.head", id_pc, BASE);
        end
        check("stall.addr", imem_addr, BASE + 32'd8);
        check("stall.instr", id_instr, rom_word(BASE));
        id_ready = 1'b1;
        tick();
        check_entry("rel1", BASE + 32'd4, 1'b0);
        tick();
        check_entry("rel2", BASE + 32'd8, 1'b0);
        tick();
        check_entry("rel3", BASE + 32'd12, 1'b0);

        // Redirect with a full queue
        id_ready = 1'b0;
        tick();
        redirect(BASE + 32'h100);
        check("rd.valid", {31'd0, id_valid}, 32'd0);
        check("rd.addr", imem_addr, BASE + 32'h100);
        id_ready = 1'b1;
        tick();
        check_entry("rd.e", BASE + 32'h100, 1'b0);

        // Misaligned redirect: one faulting entry, then fetch halts
        redirect(BASE + 32'h102);
        check("mis.valid0", {31'd0, id_valid}, 32'd0);
        tick();
        check_entry("mis.e", BASE + 32'h102, 1'b1);
        check("mis.addr", imem_addr, BASE + 32'h100);
        tick();
        check("mis.halt1", {31'd0, id_valid}, 32'd0);
        tick();
        check("mis.halt2", {31'd0, id_valid}, 32'd0);
        redirect(BASE);
        tick();
        check_entry("res.e0", BASE, 1'b0);
        tick();
        check_entry("res.e1", BASE + 32'd4, 1'b0);

        // Upper window edge
        redirect(BASE + 32'hFF8);
        tick();
        check_entry("top.ff8", BASE + 32'hFF8, 1'b0);
        tick();
        check_entry("top.ffc", BASE + 32'hFFC, 1'b0);
        tick();
        check_entry("top.end", BASE + 32'h1000, 1'b1);
        tick();
        check("top.halt", {31'd0, id_valid}, 32'd0);
        check("top.addr", imem_addr, BASE + 32'h1000);
        tick();
        check("top.halt2", {31'd0, id_valid}, 32'd0);

        // Below the window
        redirect(32'h0000_0000);
        tick();
        check_entry("low.e", 32'h0000_0000, 1'b1);
        tick();
        check("low.halt", {31'd0, id_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
